// File: rtl/gfx_pkg.sv
`timescale 1ns/1ps
// gfx_pkg: shared rasteriser front-end types and defaults (cull modes, vertex/triangle
// layout at the default coordinate width, and the cull decision helper).
package gfx_pkg;

  localparam int COORD_W_DEF = 17;
  localparam int FRAC_W_DEF  = 8;

  typedef enum logic [1:0] {
    CULL_NONE = 2'd0,
    CULL_CW   = 2'd1,
    CULL_CCW  = 2'd2,
    CULL_ALL  = 2'd3
  } cull_mode_t;

  // Default-width layouts; modules with a non-default COORD_W rebuild these locally.
  typedef logic [COORD_W_DEF-1:0] coord_t;
  typedef coord_t [1:0]           vertex_t;
  typedef vertex_t [2:0]          triangle_t;

  // Mode bit 0 culls negative (CW) area, bit 1 culls positive (CCW) area.
  function automatic logic cull_drop(input logic is_neg, input logic is_zero,
                                     input cull_mode_t mode, input logic drop_zero);
    return (is_neg && mode[0]) || (!is_neg && !is_zero && mode[1]) || (is_zero && drop_zero);
  endfunction

endpackage

// File: rtl/stall_valid_pipe.sv
`timescale 1ns/1ps
// stall_valid_pipe: DEPTH-stage valid shift register with a shared advance enable and a
// per-stage kill that turns the entry loading into that stage into a bubble.
module stall_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             advance,
  input  logic             push,
  input  logic [DEPTH-1:0] kill,
  output logic [DEPTH-1:0] stage_valid
);

  // NOTE: sequential state uses non-blocking assignments so every stage samples its
  // predecessor's pre-edge value, whatever the order the simulator runs the blocks in.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stage_valid <= '0;
    end else if (advance) begin
      stage_valid <= {stage_valid[DEPTH-2:0], push} & ~kill;
    end
  end

endmodule

// File: rtl/triangle_area_cull.sv
`timescale 1ns/1ps
// triangle_area_cull: 4-stage signed doubled-area computation with orientation and
// zero-area culling behind a full-stall valid/ready pipe. Define CULL_STATS_EN for counters.
module triangle_area_cull
  import gfx_pkg::*;
#(
  parameter int COORD_W   = COORD_W_DEF,
  parameter int FRAC_W    = FRAC_W_DEF,
  parameter int DROP_ZERO = 1,
  localparam int AREA_W   = 2 * COORD_W
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
`ifdef CULL_STATS_EN
  input  logic                            clear_stats_in,
  output logic [31:0]                     culled_count_out,
  output logic [31:0]                     accepted_count_out,
`endif
  input  logic                            valid_in,
  output logic                            ready_out,
  input  logic [2:0][1:0][COORD_W-1:0]    vertices_in,
  input  logic [1:0]                      cull_mode_in,
  output logic                            valid_out,
  input  logic                            ready_in,
  output logic                            negative_out,
  output logic [AREA_W-1:0]               area_out,
  output logic [2:0][1:0][COORD_W-1:0]    vertices_out
);

  localparam int SUM_W = AREA_W + 1;
  localparam int X = 0;
  localparam int Y = 1;

  typedef logic [COORD_W-1:0] coord_w_t;
  typedef coord_w_t [1:0]     vtx_w_t;
  typedef vtx_w_t [2:0]       tri_w_t;

  if (FRAC_W > COORD_W) begin : g_frac_check
    $error("FRAC_W must not exceed COORD_W");
  end

  logic       advance;
  logic [3:0] stage_valid;
  logic       drop;

  tri_w_t     tri1_q, tri2_q, tri3_q;
  cull_mode_t mode1_q, mode2_q, mode3_q;

  logic [5:0][AREA_W-1:0]   prod_q;
  logic signed [SUM_W-1:0]  d0_q, d1_q, d2_q, sum_q;
  logic signed [SUM_W-1:0]  abs_sum;
  logic                     sum_neg, sum_zero;

  assign advance   = !stage_valid[3] || ready_in;
  assign ready_out = advance;
  assign valid_out = stage_valid[3];

  assign sum_neg  = sum_q[SUM_W-1];
  assign sum_zero = (sum_q == '0);
  assign abs_sum  = sum_neg ? -sum_q : sum_q;
  assign drop     = stage_valid[2] && cull_drop(sum_neg, sum_zero, mode3_q, DROP_ZERO != 0);

  stall_valid_pipe #(.DEPTH(4)) u_valid_pipe (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .advance     (advance),
    .push        (valid_in),
    .kill        ({drop, 3'b000}),
    .stage_valid (stage_valid)
  );

  // NOTE: datapath registers carry no reset; the valid pipe alone says whether they
  // hold a live triangle, so resetting them would only add fan-out on rst_n_in.
  always_ff @(posedge clk_in) begin
    if (advance) begin
      // S1: the six cross products of the shoelace formula.
      prod_q[0] <= AREA_W'(vertices_in[0][X]) * AREA_W'(vertices_in[1][Y]);
      prod_q[1] <= AREA_W'(vertices_in[1][X]) * AREA_W'(vertices_in[0][Y]);
      prod_q[2] <= AREA_W'(vertices_in[1][X]) * AREA_W'(vertices_in[2][Y]);
      prod_q[3] <= AREA_W'(vertices_in[2][X]) * AREA_W'(vertices_in[1][Y]);
      prod_q[4] <= AREA_W'(vertices_in[2][X]) * AREA_W'(vertices_in[0][Y]);
      prod_q[5] <= AREA_W'(vertices_in[0][X]) * AREA_W'(vertices_in[2][Y]);
      tri1_q    <= vertices_in;
      mode1_q   <= cull_mode_t'(cull_mode_in);

      // S2: signed edge terms, one sign bit wider than the products.
      d0_q    <= $signed({1'b0, prod_q[1]}) - $signed({1'b0, prod_q[0]});
      d1_q    <= $signed({1'b0, prod_q[3]}) - $signed({1'b0, prod_q[2]});
      d2_q    <= $signed({1'b0, prod_q[5]}) - $signed({1'b0, prod_q[4]});
      tri2_q  <= tri1_q;
      mode2_q <= mode1_q;

      // S3: doubled signed area; bounded by the coordinate box so it cannot wrap.
      sum_q   <= d0_q + d1_q + d2_q;
      tri3_q  <= tri2_q;
      mode3_q <= mode2_q;

      if (stage_valid[2] && !drop) begin
        vertices_out <= tri3_q;
      end
    end
  end

  // S4 results only move when a kept triangle lands, so they stay stable under stall.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      negative_out <= 1'b0;
      area_out     <= '0;
    end else if (advance && stage_valid[2] && !drop) begin
      negative_out <= sum_neg;
      area_out     <= abs_sum[AREA_W:1];
    end
  end

`ifdef CULL_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      culled_count_out   <= '0;
      accepted_count_out <= '0;
    end else if (clear_stats_in) begin
      culled_count_out   <= '0;
      accepted_count_out <= '0;
    end else begin
      if (advance && drop && culled_count_out != '1) begin
        culled_count_out <= culled_count_out + 32'd1;
      end
      if (valid_in && ready_out && accepted_count_out != '1) begin
        accepted_count_out <= accepted_count_out + 32'd1;
      end
    end
  end
`endif

  // Truncated LSB of the magnitude and the early valid bits are consumed nowhere here.
  logic unused_bits;
  assign unused_bits = ^{abs_sum[0], stage_valid[1:0]};

endmodule

// File: tb/tb_triangle_area_cull.sv
`timescale 1ns/1ps
// tb_triangle_area_cull: directed vectors with a queue scoreboard; a DROP_ZERO=1 and a
// DROP_ZERO=0 instance, each with its own expected queue and output monitor.
module tb_triangle_area_cull;
  import gfx_pkg::*;

  localparam int CW = 17;
  localparam int AW = 2 * CW;

  typedef logic [2:0][1:0][CW-1:0] tri_t;
  typedef struct {
    tri_t            v;
    logic            neg;
    logic [AW-1:0]   area;
    bit              lat;
    int              cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  logic          clk_in    = 1'b0;
  logic          rst_n_in  = 1'b1;
  logic          valid_in  = 1'b0;
  logic          valid2_in = 1'b0;
  logic          ready_in  = 1'b1;
  tri_t          vin       = '0;
  logic [1:0]    mode      = 2'd0;

  logic          ready_out, valid_out, negative_out;
  logic [AW-1:0] area_out;
  tri_t          vertices_out;
  logic          ready2_out, valid2_out, negative2_out;
  logic [AW-1:0] area2_out;
  tri_t          vertices2_out;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit tog_en = 1'b0;

`ifdef CULL_STATS_EN
  logic        clear_stats_in = 1'b0;
  logic [31:0] culled_count_out, accepted_count_out, culled2_out, accepted2_out;
  int          exp_culled = 0;
  int          exp_acc = 0;
`endif

  triangle_area_cull #(.COORD_W(CW), .FRAC_W(8), .DROP_ZERO(1)) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
`ifdef CULL_STATS_EN
    .clear_stats_in     (clear_stats_in),
    .culled_count_out   (culled_count_out),
    .accepted_count_out (accepted_count_out),
`endif
    .valid_in           (valid_in),
    .ready_out          (ready_out),
    .vertices_in        (vin),
    .cull_mode_in       (mode),
    .valid_out          (valid_out),
    .ready_in           (ready_in),
    .negative_out       (negative_out),
    .area_out           (area_out),
    .vertices_out       (vertices_out)
  );

  triangle_area_cull #(.COORD_W(CW), .FRAC_W(8), .DROP_ZERO(0)) dut_nz (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
`ifdef CULL_STATS_EN
    .clear_stats_in     (clear_stats_in),
    .culled_count_out   (culled2_out),
    .accepted_count_out (accepted2_out),
`endif
    .valid_in           (valid2_in),
    .ready_out          (ready2_out),
    .vertices_in        (vin),
    .cull_mode_in       (mode),
    .valid_out          (valid2_out),
    .ready_in           (ready_in),
    .negative_out       (negative2_out),
    .area_out           (area2_out),
    .vertices_out       (vertices2_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic tri_t mk(input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2);
    tri_t t;
    t[0][0] = CW'(x0); t[0][1] = CW'(y0);
    t[1][0] = CW'(x1); t[1][1] = CW'(y1);
    t[2][0] = CW'(x2); t[2][1] = CW'(y2);
    return t;
  endfunction

  // Called just after a rising edge; returns just after the edge that takes the triangle.
  task automatic send(input bit second, input tri_t v, input logic [1:0] m, input bit keep,
                      input logic neg, input logic [AW-1:0] area, input bit lat);
    int   budget = 0;
    exp_t e;
    if (second) valid2_in = 1'b1; else valid_in = 1'b1;
    vin  = v;
    mode = m;
    @(negedge clk_in);
    while (!(second ? ready2_out : ready_out) && budget < 100) begin
      budget++;
      @(negedge clk_in);
    end
    check("handshake_budget", budget < 100, 1);
    if (keep) begin
      e.v = v; e.neg = neg; e.area = area; e.lat = lat; e.cyc = cyc;
      if (second) q2.push_back(e); else q1.push_back(e);
    end
`ifdef CULL_STATS_EN
    if (!second) begin
      exp_acc++;
      if (!keep) exp_culled++;
    end
`endif
    @(posedge clk_in);
    #1;
    valid_in  = 1'b0;
    valid2_in = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while ((q1.size() + q2.size()) != 0 && budget < 200) begin
      budget++;
      @(posedge clk_in);
    end
    #1;
    check("drain_pending", q1.size() + q2.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (tog_en) ready_in = ~ready_in;
    end
  end

  // Monitor for the DROP_ZERO=1 instance, including output stability across stalls.
  initial begin
    bit            hold = 1'b0;
    logic [AW-1:0] h_area;
    logic          h_neg;
    tri_t          h_v;
    exp_t          e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in) begin
        if (hold) begin
          check("hold_valid", valid_out, 1);
          check("hold_area", area_out, h_area);
          check("hold_neg", negative_out, h_neg);
          check("hold_verts", vertices_out === h_v, 1);
        end
        hold = valid_out && !ready_in;
        h_area = area_out; h_neg = negative_out; h_v = vertices_out;
        if (valid_out && ready_in) begin
          if (q1.size() == 0) begin
            check("unexpected_out", q1.size(), 1);
          end else begin
            e = q1.pop_front();
            check("area", area_out, e.area);
            check("negative", negative_out, e.neg);
            check("verts_pass", vertices_out === e.v, 1);
            if (e.lat) check("latency", cyc - e.cyc, 4);
          end
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in && valid2_out && ready_in) begin
        if (q2.size() == 0) begin
          check("nz_unexpected_out", q2.size(), 1);
        end else begin
          e = q2.pop_front();
          check("nz_area", area2_out, e.area);
          check("nz_negative", negative2_out, e.neg);
          check("nz_verts_pass", vertices2_out === e.v, 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tri_t          t_cw, t_ccw, t_col;
    logic [AW-1:0] amax;
    int            s;
    t_cw  = mk(0, 0, 256, 0, 0, 256);
    t_ccw = mk(0, 0, 0, 256, 256, 0);
    t_col = mk(0, 0, 256, 256, 512, 512);
    amax  = AW'((64'd131071 * 64'd131071) >> 1);

    ready_in = 1'b0;
    #1 rst_n_in = 1'b0;
    #11;
    check("rst_valid_out", valid_out, 0);
    check("rst_area", area_out, 0);
    check("rst_negative", negative_out, 0);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("rst_ready_out", ready_out, 1);
    ready_in = 1'b1;

    // Orientation, cull modes, degenerate and boundary vectors.
    send(0, t_cw,  2'd0, 1, 1'b1, 34'd32768, 1);
    send(0, t_ccw, 2'd0, 1, 1'b0, 34'd32768, 0);
    send(0, t_ccw, 2'd2, 0, 1'b0, '0, 0);
    send(0, t_col, 2'd0, 0, 1'b0, '0, 0);
    send(0, t_cw,  2'd1, 0, 1'b0, '0, 0);
    send(0, t_cw,  2'd2, 1, 1'b1, 34'd32768, 0);
    send(0, t_cw,  2'd3, 0, 1'b0, '0, 0);
    send(0, t_ccw, 2'd3, 0, 1'b0, '0, 0);
    send(0, mk(10, 20, 100, 30, 40, 90), 2'd0, 1, 1'b1, 34'd3000, 0);
    send(0, mk(0, 0, 3, 0, 0, 3), 2'd0, 1, 1'b1, 34'd4, 0);
    send(0, mk(0, 0, 131071, 0, 0, 131071), 2'd0, 1, 1'b1, amax, 0);
    drain();

    // Alternating CW/CCW stream under cull-CW with ready_in toggling every cycle.
    tog_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      s = 16 * k;
      if (k % 2 == 1) send(0, mk(0, 0, s, 0, 0, s), 2'd1, 0, 1'b0, '0, 0);
      else            send(0, mk(0, 0, 0, s, s, 0), 2'd1, 1, 1'b0, AW'(128 * k * k), 0);
    end
    drain();
    tog_en = 1'b0;
    @(posedge clk_in);
    #1 ready_in = 1'b1;

    // Reset pulse with the pipe full discards everything in flight.
    for (int k = 2; k <= 5; k++) begin
      s = 16 * k;
      send(0, mk(0, 0, 0, s, s, 0), 2'd0, 1, 1'b0, AW'(s * s / 2), 0);
    end
    check("pre_reset_valid", valid_out, 1);
    rst_n_in = 1'b0;
    #0.5;
    check("reset_valid_async", valid_out, 0);
    q1.delete();
`ifdef CULL_STATS_EN
    exp_culled = 0;
    exp_acc = 0;
`endif
    #0.5 rst_n_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check("no_stale_out", valid_out, 0);
    end
    @(posedge clk_in);
    #1;
    send(0, mk(0, 0, 0, 64, 64, 0), 2'd0, 1, 1'b0, 34'd2048, 1);
    drain();

`ifdef CULL_STATS_EN
    check("culled_count", culled_count_out, exp_culled);
    check("accepted_count", accepted_count_out, exp_acc);
    clear_stats_in = 1'b1;
    @(posedge clk_in);
    #1 clear_stats_in = 1'b0;
    check("culled_clear", culled_count_out, 0);
    check("accepted_clear", accepted_count_out, 0);
`endif

    // DROP_ZERO=0: zero-area triangles survive every mode.
    send(1, t_col, 2'd3, 1, 1'b0, '0, 0);
    send(1, t_cw,  2'd0, 1, 1'b1, 34'd32768, 0);
    send(1, t_col, 2'd0, 1, 1'b0, '0, 0);
    send(1, t_ccw, 2'd2, 0, 1'b0, '0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
